// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player for the memory game.
// Learns the LED sequence shown by the game during its show phase. It then
// replays that sequence as timed one-hot button presses. It re-learns the
// sequence every round and parks while the game reports end-of-game.
module jogador_automatico #(
    parameter int MAX_JOGADAS  = 16,
    parameter int QUIET_CYCLES = 16,
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               habilita,
    input  logic [3:0]                         leds,
    input  logic                               pronto,
    output logic [3:0]                         botoes,
    output logic [$clog2(MAX_JOGADAS+1)-1:0]   tamanho,
    output logic                               erro,
    output logic [3:0]                         db_estado
);

    localparam int TW  = $clog2(MAX_JOGADAS + 1);
    localparam int IW  = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam int QW  = $clog2(QUIET_CYCLES + 1);
    localparam int TMX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TMW = $clog2(TMX + 1);

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        ESCUTA    = 4'd1,
        ACESO     = 4'd2,
        PRESSIONA = 4'd3,
        SOLTA     = 4'd4,
        FIM       = 4'd5
    } estado_t;

    estado_t        estado;
    logic [IW-1:0]  idx;
    logic [QW-1:0]  q;
    logic [TMW-1:0] timer;
    logic [3:0]     mem [MAX_JOGADAS];

    logic           leds_on;
    logic           multi_hot;
    logic           cheio;
    logic           cap_we;
    logic           ultimo;
    logic           q_fim;
    logic           press_fim;
    logic           gap_fim;

    // Capture qualifiers. The write strobe mirrors the ESCUTA branch of the
    // FSM, including the priority of habilita and pronto.
    always_comb begin
        leds_on   = (leds != 4'd0);
        multi_hot = ((leds & (leds - 4'd1)) != 4'd0);
        cheio     = (tamanho == TW'(MAX_JOGADAS));
        cap_we    = habilita && !pronto && (estado == ESCUTA) && leds_on && !cheio;
        ultimo    = (TW'(idx) == (tamanho - TW'(1)));
        q_fim     = (q == QW'(QUIET_CYCLES - 1));
        press_fim = (timer == TMW'(PRESS_CYCLES - 1));
        gap_fim   = (timer == TMW'(GAP_CYCLES - 1));
    end

    // Sequence memory. It has no reset because its contents are only
    // meaningful below tamanho. The write is never issued when full, so
    // the truncated address is always in range.
    always_ff @(posedge clock) begin
        if (cap_we)
            mem[tamanho[IW-1:0]] <= leds;
    end

    // Main FSM. botoes is registered and loaded on the edge that enters
    // PRESSIONA, which keeps the outputs free of input paths.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            botoes  <= 4'd0;
            tamanho <= '0;
            erro    <= 1'b0;
            idx     <= '0;
            q       <= '0;
            timer   <= '0;
        end else if (!habilita) begin
            // Disable wins over everything and leaves a clean learner.
            estado  <= OCIOSO;
            botoes  <= 4'd0;
            tamanho <= '0;
            erro    <= 1'b0;
            idx     <= '0;
            q       <= '0;
            timer   <= '0;
        end else if (pronto && (estado != OCIOSO)) begin
            // End of game: release the buttons and park.
            estado <= FIM;
            botoes <= 4'd0;
            timer  <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    tamanho <= '0;
                    idx     <= '0;
                    erro    <= 1'b0;
                    q       <= '0;
                    estado  <= ESCUTA;
                end

                ESCUTA: begin
                    if (leds_on) begin
                        // First lit edge is the capture; ACESO absorbs the rest.
                        estado <= ACESO;
                        if (cheio)
                            erro <= 1'b1;
                        else
                            tamanho <= tamanho + TW'(1);
                        if (multi_hot)
                            erro <= 1'b1;
                    end else if (q_fim && (tamanho != '0)) begin
                        // The show phase has ended, so start the replay at entry 0.
                        estado <= PRESSIONA;
                        idx    <= '0;
                        timer  <= '0;
                        botoes <= mem[0];
                    end else if (!q_fim) begin
                        q <= q + QW'(1);
                    end
                end

                ACESO: begin
                    if (!leds_on) begin
                        estado <= ESCUTA;
                        q      <= '0;
                    end
                end

                PRESSIONA: begin
                    if (press_fim) begin
                        estado <= SOLTA;
                        timer  <= '0;
                        botoes <= 4'd0;
                    end else begin
                        timer <= timer + TMW'(1);
                    end
                end

                SOLTA: begin
                    if (gap_fim) begin
                        timer <= '0;
                        if (ultimo) begin
                            // Replay done: forget the sequence and listen again.
                            estado  <= ESCUTA;
                            tamanho <= '0;
                            idx     <= '0;
                            q       <= '0;
                        end else begin
                            estado <= PRESSIONA;
                            idx    <= idx + IW'(1);
                            botoes <= mem[idx + IW'(1)];
                        end
                    end else begin
                        timer <= timer + TMW'(1);
                    end
                end

                FIM: begin
                    // Only reached with pronto low, so the game has restarted.
                    botoes  <= 4'd0;
                    estado  <= ESCUTA;
                    tamanho <= '0;
                    idx     <= '0;
                    q       <= '0;
                end

                default: begin
                    estado <= OCIOSO;
                    botoes <= 4'd0;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: directed LED shows. Each expected botoes change
// (value and cycle) is queued by the stimulus and matched by a monitor.
module tb_jogador_automatico;

    localparam int Q   = 16;
    localparam int M   = 16;
    localparam int LAT = Q + 1;   // cycles from the leds-drop negedge to the first press

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] leds;
    logic       pronto;
    logic [3:0] botoes;
    logic [4:0] tamanho;
    logic       erro;
    logic [3:0] db_estado;

    jogador_automatico #(
        .MAX_JOGADAS (M),
        .QUIET_CYCLES(Q),
        .PRESS_CYCLES(4),
        .GAP_CYCLES  (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita),
        .leds     (leds),
        .pronto   (pronto),
        .botoes   (botoes),
        .tamanho  (tamanho),
        .erro     (erro),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] v;
        int         c;
    } ev_t;

    ev_t        expq[$];
    logic [3:0] seq[$];      // model of the captured sequence
    logic [3:0] prev_b = 4'd0;
    ev_t        got;

    // Monitor: every change on botoes must match the next queued event.
    always @(negedge clock) begin
        if (botoes !== prev_b) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_botoes: got %b at cycle %0d, required no change", botoes, cyc);
            end else begin
                got = expq.pop_front();
                if (botoes !== got.v || cyc != got.c) begin
                    errors++;
                    $display("FAIL botoes_event: got %b at cycle %0d, required %b at cycle %0d",
                             botoes, cyc, got.v, got.c);
                end
            end
            prev_b = botoes;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [3:0] v, input int c);
        ev_t e;
        e.v = v;
        e.c = c;
        expq.push_back(e);
    endtask

    // Show one LED for 'on' cycles, then go dark; returns the drop cycle.
    task automatic show(input logic [3:0] v, input int on, output int drop);
        leds = v;
        if (seq.size() < M) seq.push_back(v);
        tick(on);
        leds = 4'd0;
        drop = cyc;
    endtask

    // Queue the full replay of the modelled sequence.
    task automatic plan_replay(input int drop, output int s);
        s = drop + LAT;
        foreach (seq[i]) begin
            push(seq[i], s + 8 * i);
            push(4'd0,   s + 8 * i + 4);
        end
        seq.delete();
    endtask

    int d, s;

    initial begin
        reset = 1'b1; habilita = 1'b0; leds = 4'd0; pronto = 1'b0;
        tick(2);
        chk("reset_botoes",  botoes,    0);
        chk("reset_tamanho", tamanho,   0);
        chk("reset_erro",    erro,      0);
        chk("reset_estado",  db_estado, 0);

        reset = 1'b0; habilita = 1'b1;
        tick(2);
        chk("escuta_after_enable", db_estado, 1);

        // Single LED
        show(4'b0001, 5, d);
        chk("single_tamanho", tamanho, 1);
        plan_replay(d, s);
        tick(s + 10 - cyc);
        chk("single_back_escuta", db_estado, 1);
        chk("single_tamanho_cleared", tamanho, 0);

        // Three-LED sequence
        show(4'b0010, 5, d); tick(8);
        show(4'b1000, 5, d); tick(8);
        show(4'b0100, 5, d);
        chk("three_tamanho", tamanho, 3);
        plan_replay(d, s);
        tick(s + 26 - cyc);
        chk("three_back_escuta", db_estado, 1);

        // End of game during the second press
        show(4'b0001, 5, d); tick(8);
        show(4'b0010, 5, d); tick(8);
        show(4'b0100, 5, d);
        s = d + LAT;
        push(4'b0001, s); push(4'd0, s + 4); push(4'b0010, s + 8); push(4'd0, s + 10);
        seq.delete();
        tick(s + 9 - cyc);
        pronto = 1'b1;
        tick(1);
        chk("pronto_estado_fim", db_estado, 5);
        chk("pronto_botoes", botoes, 0);
        pronto = 1'b0;
        tick(1);
        chk("pronto_release_estado", db_estado, 1);
        chk("pronto_release_tamanho", tamanho, 0);

        // Overflow: 17 pulses, only 16 kept
        for (int i = 0; i < 17; i++) begin
            show(4'(1 << (i % 4)), 2, d);
            if (i < 16) tick(8);
        end
        chk("overflow_tamanho", tamanho, 16);
        chk("overflow_erro", erro, 1);
        plan_replay(d, s);
        tick(s + 130 - cyc);
        chk("overflow_erro_sticky", erro, 1);
        chk("overflow_tamanho_cleared", tamanho, 0);

        // Disable clears erro
        habilita = 1'b0;
        tick(1);
        chk("disable_estado", db_estado, 0);
        chk("disable_erro", erro, 0);
        habilita = 1'b1;
        tick(1);

        // Multi-hot capture is kept and replayed
        show(4'b0011, 5, d);
        chk("multihot_erro", erro, 1);
        chk("multihot_tamanho", tamanho, 1);
        plan_replay(d, s);
        tick(s + 10 - cyc);

        // Async reset in the middle of a press (erro still set going in)
        chk("pre_reset_erro", erro, 1);
        show(4'b1000, 5, d);
        s = d + LAT;
        push(4'b1000, s);
        seq.delete();
        tick(s + 1 - cyc);
        #3 reset = 1'b1;
        #1;
        chk("midreset_botoes",  botoes,    0);
        chk("midreset_tamanho", tamanho,   0);
        chk("midreset_erro",    erro,      0);
        chk("midreset_estado",  db_estado, 0);
        push(4'd0, s + 2);
        tick(2);
        reset = 1'b0;
        tick(2);

        // habilita low mid-replay
        show(4'b0101, 5, d);
        chk("multihot2_erro", erro, 1);
        s = d + LAT;
        push(4'b0101, s);
        seq.delete();
        tick(s + 1 - cyc);
        habilita = 1'b0;
        push(4'd0, s + 2);
        tick(1);
        chk("hab_low_estado",  db_estado, 0);
        chk("hab_low_erro",    erro,      0);
        chk("hab_low_tamanho", tamanho,   0);
        chk("hab_low_botoes",  botoes,    0);

        tick(4);
        chk("events_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
